// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer with compare match,
// one-shot / auto-reload modes and a level interrupt. Registered read path
// with one cycle of latency (read-old on same-cycle writes).
module mmio_timer #(
   parameter int unsigned PRESCALE_W = 16,
   parameter logic [31:0] ID_VALUE   = 32'h4B54_4D52
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sel,
   input  logic [2:0]  address,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q,
   output logic        irq
);

   typedef enum logic [2:0] {
      OFF_CTRL     = 3'd0,
      OFF_PRESCALE = 3'd1,
      OFF_COMPARE  = 3'd2,
      OFF_COUNT    = 3'd3,
      OFF_STATUS   = 3'd4,
      OFF_ID       = 3'd5
   } reg_off_e;

   localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

   logic                  en, auto_rl, irq_en;
   logic                  en_n, auto_n, irq_en_n;
   logic [PRESCALE_W-1:0] prescale, prescale_n;
   logic [PRESCALE_W-1:0] pre_cnt, pre_cnt_n;
   logic [31:0]           compare, compare_n;
   logic [31:0]           count, count_n;
   logic                  match, match_n;
   logic                  overrun, overrun_n;
   logic [31:0]           rd_val;

   logic wr, wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
   logic tick, hit, clr_match, clr_ovr;

   assign wr          = sel & wren;
   assign wr_ctrl     = wr && (address == OFF_CTRL);
   assign wr_prescale = wr && (address == OFF_PRESCALE);
   assign wr_compare  = wr && (address == OFF_COMPARE);
   assign wr_count    = wr && (address == OFF_COUNT);
   assign wr_status   = wr && (address == OFF_STATUS);

   assign tick      = en && (pre_cnt == prescale);
   assign hit       = tick && (count == compare);
   assign clr_match = wr_status & data[0];
   assign clr_ovr   = wr_status & data[1];

   // Next-state logic: bus writes take priority over timer-driven updates
   always_comb begin
      en_n     = en;
      auto_n   = auto_rl;
      irq_en_n = irq_en;
      if (hit && !auto_rl)
         en_n = 1'b0;
      if (wr_ctrl) begin
         en_n     = data[0];
         auto_n   = data[1];
         irq_en_n = data[2];
      end

      prescale_n = wr_prescale ? data[PRESCALE_W-1:0] : prescale;
      compare_n  = wr_compare  ? data : compare;

      pre_cnt_n = pre_cnt;
      if (en)
         pre_cnt_n = tick ? '0 : pre_cnt + PRE_ONE;
      if (wr_prescale || (wr_ctrl && data[0] && !en))
         pre_cnt_n = '0;

      count_n = count;
      if (tick)
         count_n = hit ? (auto_rl ? '0 : count) : count + 32'd1;
      if (wr_count)
         count_n = data;

      // A new match always sets MATCH; it only counts as an overrun if the
      // previous MATCH was still pending and not being cleared this edge.
      match_n   = hit | (match & ~clr_match);
      overrun_n = (overrun & ~clr_ovr) | (hit & match & ~clr_match);
   end

   // Read mux over pre-edge register values
   always_comb begin
      rd_val = '0;
      case (address)
         OFF_CTRL:     rd_val = {29'd0, irq_en, auto_rl, en};
         OFF_PRESCALE: rd_val = 32'(prescale);
         OFF_COMPARE:  rd_val = compare;
         OFF_COUNT:    rd_val = count;
         OFF_STATUS:   rd_val = {30'd0, overrun, match};
         OFF_ID:       rd_val = ID_VALUE;
         default:      rd_val = '0;
      endcase
   end

   // State, read data and interrupt registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en       <= 1'b0;
         auto_rl  <= 1'b0;
         irq_en   <= 1'b0;
         prescale <= '0;
         pre_cnt  <= '0;
         compare  <= '0;
         count    <= '0;
         match    <= 1'b0;
         overrun  <= 1'b0;
         q        <= '0;
         irq      <= 1'b0;
      end else begin
         en       <= en_n;
         auto_rl  <= auto_n;
         irq_en   <= irq_en_n;
         prescale <= prescale_n;
         pre_cnt  <= pre_cnt_n;
         compare  <= compare_n;
         count    <= count_n;
         match    <= match_n;
         overrun  <= overrun_n;
         q        <= sel ? rd_val : '0;
         irq      <= match_n & irq_en_n;
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed table-driven bench for mmio_timer. Each vector is
// one clock edge; expected q is the pre-edge register value, expected irq is
// the post-edge value.
module tb_mmio_timer;

   localparam logic [31:0] ID = 32'h4B54_4D52;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sel;
   logic [2:0]  address;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q;
   logic        irq;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic        sel;
      logic        wren;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_q;
      logic        exp_irq;
   } vec_t;

   vec_t va[$];
   vec_t vb[$];

   mmio_timer #(
      .PRESCALE_W(16),
      .ID_VALUE  (ID)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .sel    (sel),
      .address(address),
      .data   (data),
      .wren   (wren),
      .q      (q),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   function automatic vec_t rd(input logic [2:0] a, input logic [31:0] eq, input logic ei);
      vec_t v;
      v.sel = 1'b1; v.wren = 1'b0; v.addr = a; v.data = '0; v.exp_q = eq; v.exp_irq = ei;
      return v;
   endfunction

   function automatic vec_t wr(input logic [2:0] a, input logic [31:0] d,
                               input logic [31:0] eq, input logic ei);
      vec_t v;
      v.sel = 1'b1; v.wren = 1'b1; v.addr = a; v.data = d; v.exp_q = eq; v.exp_irq = ei;
      return v;
   endfunction

   function automatic vec_t nosel(input logic [2:0] a);
      vec_t v;
      v.sel = 1'b0; v.wren = 1'b0; v.addr = a; v.data = '0; v.exp_q = '0; v.exp_irq = 1'b0;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] got_q, input logic [31:0] exp_q,
                        input logic got_irq, input logic exp_irq);
      n_vec++;
      if (got_q !== exp_q) begin
         n_bad++;
         $display("FAIL %s[%0d] q: got %h, expected %h", name, idx, got_q, exp_q);
      end
      if (got_irq !== exp_irq) begin
         n_bad++;
         $display("FAIL %s[%0d] irq: got %b, expected %b", name, idx, got_irq, exp_irq);
      end
   endtask

   task automatic apply(input vec_t v, input string name, input int idx);
      @(negedge clk);
      sel     = v.sel;
      wren    = v.wren;
      address = v.addr;
      data    = v.data;
      @(posedge clk);
      #1;
      check(name, idx, q, v.exp_q, irq, v.exp_irq);
   endtask

   initial begin
      // ---- basic reads ----
      va.push_back(rd(5, ID, 0));
      va.push_back(rd(6, 0, 0));
      va.push_back(rd(7, 0, 0));
      va.push_back(nosel(5));
      va.push_back(wr(6, 32'hFFFF_FFFF, 0, 0));
      va.push_back(rd(0, 0, 0));
      // ---- auto-reload, PRESCALE=0, COMPARE=3 ----
      va.push_back(wr(1, 0, 0, 0));
      va.push_back(wr(2, 3, 0, 0));
      va.push_back(wr(0, 3, 0, 0));
      va.push_back(rd(3, 0, 0));
      va.push_back(rd(3, 1, 0));
      va.push_back(rd(3, 2, 0));
      va.push_back(rd(3, 3, 0));           // match edge, count -> 0
      va.push_back(rd(4, 1, 0));
      va.push_back(rd(3, 1, 0));
      va.push_back(rd(3, 2, 0));
      va.push_back(rd(3, 3, 0));           // second match -> overrun
      va.push_back(rd(4, 3, 0));
      va.push_back(rd(3, 1, 0));
      va.push_back(rd(3, 2, 0));
      va.push_back(wr(4, 3, 3, 0));        // W1C with match in same edge
      va.push_back(rd(4, 1, 0));
      va.push_back(wr(0, 0, 3, 0));        // stop; last tick 1->2
      va.push_back(wr(4, 1, 1, 0));
      va.push_back(rd(3, 2, 0));           // held while EN=0
      // ---- one-shot with irq, PRESCALE=2, COMPARE=1 ----
      va.push_back(wr(3, 0, 2, 0));
      va.push_back(wr(1, 2, 0, 0));
      va.push_back(wr(2, 1, 3, 0));
      va.push_back(wr(0, 5, 0, 0));
      va.push_back(rd(3, 0, 0));
      va.push_back(rd(3, 0, 0));
      va.push_back(rd(3, 0, 0));           // tick: count 0->1
      va.push_back(rd(3, 1, 0));
      va.push_back(rd(3, 1, 0));
      va.push_back(rd(0, 5, 1));           // match tick: EN clears, irq rises
      va.push_back(rd(0, 4, 1));
      va.push_back(rd(3, 1, 1));
      va.push_back(wr(4, 1, 1, 0));        // clear MATCH -> irq drops
      va.push_back(rd(4, 0, 0));
      // ---- wrap and COUNT-write priority, PRESCALE=0, COMPARE=5 ----
      va.push_back(wr(1, 0, 2, 0));
      va.push_back(wr(2, 5, 1, 0));
      va.push_back(wr(3, 32'hFFFF_FFFF, 1, 0));
      va.push_back(wr(0, 1, 4, 0));
      va.push_back(rd(3, 32'hFFFF_FFFF, 0));
      va.push_back(rd(3, 0, 0));
      va.push_back(rd(4, 0, 0));           // wrap did not set MATCH
      va.push_back(wr(3, 32'h10, 2, 0));   // write beats tick
      va.push_back(rd(3, 32'h10, 0));
      va.push_back(rd(3, 32'h11, 0));
      // ---- CTRL write beats one-shot EN clear ----
      va.push_back(wr(3, 5, 32'h12, 0));
      va.push_back(wr(0, 1, 1, 0));        // match edge, EN kept by write
      va.push_back(rd(0, 1, 0));           // match again, EN clears
      va.push_back(rd(4, 3, 0));
      va.push_back(rd(0, 0, 0));
      // ---- set up live counting before async reset ----
      va.push_back(wr(0, 7, 0, 1));
      va.push_back(rd(3, 5, 1));
      va.push_back(rd(4, 3, 1));
      // ---- after reset: idle until CTRL is written ----
      vb.push_back(rd(3, 0, 0));
      vb.push_back(rd(0, 0, 0));
      vb.push_back(rd(4, 0, 0));
      vb.push_back(rd(3, 0, 0));
      vb.push_back(wr(0, 1, 0, 0));
      vb.push_back(rd(3, 0, 0));           // COUNT 0 == COMPARE 0: one-shot
      vb.push_back(rd(4, 1, 0));
      vb.push_back(rd(0, 0, 0));

      reset_n = 1'b0;
      sel = 1'b0; wren = 1'b0; address = '0; data = '0;
      #1;
      check("reset_init", 0, q, 32'h0, irq, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      foreach (va[i]) apply(va[i], "seqA", i);

      // Asynchronous reset between edges while the last read left q/irq set
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", 0, q, 32'h0, irq, 1'b0);
      sel = 1'b0; wren = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      foreach (vb[i]) apply(vb[i], "seqB", i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral that acts as the responder on the CPU's word-addressed, RAM-style data port (address/data/wren/q).
- It sits beside the main RAM. Top-level address decode drives `sel`. The read path is registered, so it matches the synchronous-RAM read latency the pipeline already tolerates.
- It provides a prescaled 32-bit up-counter, a compare match, one-shot or auto-reload modes, and a level interrupt.

Parameters:
- PRESCALE_W, 16, width of the prescaler reload register and the prescaler counter.
- ID_VALUE, 32'h4B54_4D52, constant returned by the ID register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  1  access targets this block (from top-level decode).
- address  in  3  word offset within the block (CPU byte address bits [4:2]).
- data  in  32  write data.
- wren  in  1  write strobe; effective only when sel=1.
- q  out  32  read data, registered, valid the cycle after the address is presented.
- irq  out  1  interrupt request, level, registered.

Behaviour:
- Reset: every register, prescaler counter, q and irq are 0. Reset is asynchronous and may occur mid-count; state clears immediately and the block stays idle until CTRL is written.
- Register map (word offset):
  - 0 CTRL (RW): bit0 EN, bit1 AUTO, bit2 IRQ_EN; other bits read 0.
  - 1 PRESCALE (RW): [PRESCALE_W-1:0]; upper bits read 0.
  - 2 COMPARE (RW): 32 bits.
  - 3 COUNT (RW): 32 bits; a write loads the counter.
  - 4 STATUS: bit0 MATCH, bit1 OVERRUN; both write-1-to-clear.
  - 5 ID (RO): ID_VALUE.
  - 6, 7: read 0, writes ignored.
- Read:
  - On each edge, q <= selected register if sel=1, else 0. Latency is exactly 1 cycle.
  - The value read is the pre-edge value (read-old), even when a write to the same register happens in the same cycle.
  - wren=1 with sel=1 still updates q.
- Write: takes effect at the edge where sel=1 and wren=1.
- Prescaler:
  - pre_cnt counts while EN=1.
  - tick = EN & (pre_cnt == PRESCALE). On a tick, pre_cnt <= 0; otherwise pre_cnt <= pre_cnt+1.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE, or writing CTRL with EN=1 while EN was 0, forces pre_cnt <= 0.
  - When EN=0, pre_cnt holds.
- Counter, on a tick, using the pre-edge COUNT value:
  - If COUNT == COMPARE: MATCH <= 1 and OVERRUN <= OVERRUN | MATCH. Then COUNT <= 0 if AUTO=1; if AUTO=0, COUNT holds and EN <= 0 (one-shot).
  - Otherwise COUNT <= COUNT+1, modulo 2^32. 0xFFFF_FFFF wraps to 0 and does not set MATCH.
- Simultaneous events:
  - A COUNT write beats a tick update; the prescaler still advances.
  - A CTRL write beats the one-shot EN clear.
  - A STATUS W1C and a new MATCH set in the same edge: the set wins, and OVERRUN is evaluated with the pre-edge MATCH.
- irq <= MATCH_next & IRQ_EN_next, i.e. it is registered and follows one cycle after the flag or enable changes.

Test Plan:
- Release reset, then read offset 5 → q=0x4B54_4D52 exactly one cycle later. Reads of offsets 6/7 → 0. sel=0 → q=0. irq=0.
- PRESCALE=0, COMPARE=3, CTRL=0x3 → COUNT reads 1,2,3 on successive ticks. On the 4th tick MATCH=1 and COUNT=0. Counting continues, irq stays 0, and STATUS reads 0x1.
- PRESCALE=2, COMPARE=1, CTRL=0x5 → ticks every 3 cycles. On the tick with COUNT=1, MATCH=1 and EN clears; irq=1 the next cycle; CTRL reads 0x4. Writing STATUS=0x1 → irq=0 one cycle after the MATCH clear.
- Auto-reload with MATCH already 1 and a second match → STATUS=0x3. Then a W1C of 0x3 in the same edge as a further match → STATUS=0x1.
- COUNT=0xFFFF_FFFF, COMPARE=5, PRESCALE=0, EN=1 → next read 0; MATCH not set. A COUNT write of 0x10 in a tick cycle → COUNT=0x10, not 0x11.
- Assert reset_n low mid-count between clock edges → COUNT, CTRL, STATUS, q and irq read 0 immediately. After release, the block stays idle until CTRL is written.
